// File: rtl/regfile_issue.sv
// Register file, operand fetch/issue and writeback stage in front of the ALU.
// One-cycle execute register; results bypass into a same-edge issue; hold freezes everything.
module regfile_issue #(
  parameter int NREGS = 8,
  parameter int DW    = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic          in_use_imm,
  input  logic [DW-1:0] in_imm,
  input  logic          hold,
  output logic [3:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_out,
  output logic          ex_valid,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] r_rf [NREGS];
  logic [3:0]    r_op;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [AW-1:0] r_ex_rd;
  logic          r_ex_vld;

  logic          w_wb_en;
  logic          w_accept;
  logic [DW-1:0] w_rs1_val;
  logic [DW-1:0] w_rs2_val;

  assign w_wb_en  = r_ex_vld & ~hold;
  assign w_accept = in_valid & ~hold;

  // A writeback landing on the same edge is forwarded so dependent issue never stalls.
  assign w_rs1_val = (in_rs1 == '0) ? '0 :
                     (w_wb_en && r_ex_rd == in_rs1) ? alu_out : r_rf[in_rs1];
  assign w_rs2_val = (in_rs2 == '0) ? '0 :
                     (w_wb_en && r_ex_rd == in_rs2) ? alu_out : r_rf[in_rs2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_ex_rd  <= '0;
      r_ex_vld <= 1'b0;
    end else if (!hold) begin
      if (w_accept) begin
        r_op     <= in_op;
        r_a      <= w_rs1_val;
        r_b      <= in_use_imm ? in_imm : w_rs2_val;
        r_ex_rd  <= in_rd;
        r_ex_vld <= 1'b1;
      end else begin
        r_ex_vld <= 1'b0;
      end
      if (w_wb_en && r_ex_rd != '0) r_rf[r_ex_rd] <= alu_out;
    end
  end

  assign in_ready = ~hold;
  assign alu_op   = r_op;
  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign ex_valid = r_ex_vld;
  assign wb_en    = w_wb_en;
  assign wb_addr  = r_ex_rd;
  assign wb_data  = alu_out;
  assign dbg_data = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];

endmodule

// File: tb/tb_regfile_issue.sv
// Bench for regfile_issue: directed scenarios then random traffic against a sequential register model.
module tb_regfile_issue;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_op = '0;
  logic [2:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic       in_use_imm = 1'b0;
  logic [7:0] in_imm = '0;
  logic       hold = 1'b0;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       ex_valid, wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic [2:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Sequential reference: retire the in-flight op, then read operands for the new one.
  logic [7:0] m_rf [8];
  logic       m_ex_vld;
  logic [3:0] m_op;
  logic [2:0] m_rd;
  logic [7:0] m_a, m_b;

  always #20 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_out = alu_f(alu_op, alu_a, alu_b);

  regfile_issue #(.NREGS(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .hold(hold),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .ex_valid(ex_valid), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] x);
    return (x == 3'd0) ? 8'h00 : m_rf[x];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    m_ex_vld = 1'b0; m_op = '0; m_rd = '0; m_a = '0; m_b = '0;
  endtask

  task automatic peek(input string tag, input logic [2:0] idx, input logic [7:0] exp);
    dbg_addr = idx;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic check_state();
    chk("ex_valid", ex_valid, m_ex_vld);
    chk("alu_op", alu_op, m_op);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    for (int i = 0; i < 8; i++) peek($sformatf("dbg_r%0d", i), 3'(i), m_rf[i]);
  endtask

  task automatic step(input logic v, input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic ui, input logic [7:0] imm, input logic h);
    @(negedge clk);
    in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_use_imm = ui; in_imm = imm; hold = h;
    #1;
    chk("in_ready", in_ready, !h);
    chk("wb_en", wb_en, m_ex_vld && !h);
    if (m_ex_vld) begin
      chk("wb_addr", wb_addr, m_rd);
      chk("wb_data", wb_data, alu_f(m_op, m_a, m_b));
    end
    if (!h) begin
      if (m_ex_vld && m_rd != 3'd0) m_rf[m_rd] = alu_f(m_op, m_a, m_b);
      if (v) begin
        m_op = op; m_rd = rd; m_a = m_read(rs1);
        m_b = ui ? imm : m_read(rs2);
        m_ex_vld = 1'b1;
      end else begin
        m_ex_vld = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    model_reset();
    #5;
    check_state();
    chk("in_ready_rst", in_ready, 1'b1);
    chk("wb_en_rst", wb_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Immediate load, dependent add through the bypass, then register-register SUB.
    step(1, OP_ADD, 3'd1, 3'd0, 3'd0, 1, 8'd5, 0);
    step(1, OP_ADD, 3'd2, 3'd1, 3'd0, 1, 8'd7, 0);
    step(1, OP_SUB, 3'd3, 3'd2, 3'd1, 0, 8'd0, 0);
    peek("r1_eq5", 3'd1, 8'd5);
    peek("r2_eq12", 3'd2, 8'd12);
    chk("sub_a", alu_a, 8'd12);
    chk("sub_b", alu_b, 8'd5);
    step(1, OP_ADD, 3'd4, 3'd0, 3'd0, 1, 8'd200, 0);
    peek("r3_eq7", 3'd3, 8'd7);

    // Wrap modulo 256 and writes to r0 are dropped.
    step(1, OP_ADD, 3'd4, 3'd4, 3'd0, 1, 8'd100, 0);
    step(1, OP_ADD, 3'd0, 3'd4, 3'd0, 1, 8'd1, 0);
    step(0, OP_ADD, 3'd0, 3'd0, 3'd0, 0, 8'd0, 0);
    peek("r4_wrap44", 3'd4, 8'd44);
    peek("r0_zero", 3'd0, 8'd0);

    // Hold for three cycles with a live op and a waiting instruction.
    step(1, OP_ADD, 3'd5, 3'd0, 3'd0, 1, 8'd9, 0);
    for (int k = 0; k < 3; k++) step(1, OP_ADD, 3'd7, 3'd5, 3'd0, 1, 8'd1, 1);
    peek("r5_frozen", 3'd5, 8'd0);
    step(1, OP_ADD, 3'd7, 3'd5, 3'd0, 1, 8'd1, 0);
    peek("r5_eq9", 3'd5, 8'd9);
    chk("held_accept_a", alu_a, 8'd9);

    // Bubbles.
    step(0, OP_ADD, 3'd0, 3'd0, 3'd0, 0, 8'd0, 0);
    step(0, OP_ADD, 3'd0, 3'd0, 3'd0, 0, 8'd0, 0);
    peek("r7_eq10", 3'd7, 8'd10);
    chk("bubble_exv", ex_valid, 1'b0);

    // Asynchronous reset between accept and writeback.
    step(1, OP_ADD, 3'd6, 3'd0, 3'd0, 1, 8'd3, 0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    rst_n = 1'b1;
    step(0, OP_ADD, 3'd0, 3'd0, 3'd0, 0, 8'd0, 0);
    peek("r6_never", 3'd6, 8'd0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 4)), 3'($urandom), 3'($urandom), 3'($urandom),
           1'($urandom), 8'($urandom), $urandom_range(0, 9) < 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_issue.md
Name: regfile_issue

Overview:
- Operand-fetch, issue and writeback stage sitting directly upstream of the 8-bit ALU.
- Holds the CPU's eight 8-bit general registers and accepts decoded instructions over a valid/ready handshake.
- Drives the ALU's aluop/a/b inputs from an execute register and writes the ALU result back to the destination register one cycle later.
- Includes a bypass so that back-to-back dependent instructions issue without stalling.

Parameters:
- NREGS, 8, number of architectural registers; r0 is hardwired to zero.
- DW, 8, data width; must match the ALU width.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  a decoded instruction is presented.
- in_ready  out  1  stage can accept the presented instruction.
- in_op  in  4  ALU opcode (ALUOP_* values from defines.v).
- in_rd  in  3  destination register index.
- in_rs1  in  3  source register index for operand a.
- in_rs2  in  3  source register index for operand b.
- in_use_imm  in  1  when 1, operand b is in_imm instead of the in_rs2 register.
- in_imm  in  DW  immediate value.
- hold  in  1  global freeze request from the controller.
- alu_op  out  4  opcode to the ALU.
- alu_a  out  DW  operand a to the ALU.
- alu_b  out  DW  operand b to the ALU.
- alu_out  in  DW  combinational ALU result.
- ex_valid  out  1  the execute register holds a live instruction.
- wb_en  out  1  writeback occurs at the next clock edge.
- wb_addr  out  3  writeback register index.
- wb_data  out  DW  writeback data; equals alu_out.
- dbg_addr  in  3  debug read index.
- dbg_data  out  DW  combinational read of the register file; no bypass applied.

Behaviour:
- Reset (asynchronous, rst_n=0): all registers r0..r7 = 0; alu_op = 0; alu_a = 0; alu_b = 0; ex_valid = 0; ex_rd = 0.
  - wb_en = 0 while ex_valid = 0.
  - An in-flight instruction is discarded and never written back.
- Handshake:
  - in_ready = !hold, combinational.
  - An instruction is accepted on a rising edge where in_valid & in_ready.
  - in_valid may stay high across cycles; each accepting edge consumes one instruction.
- Operand read, read(x):
  - x = 0 -> 0.
  - else if wb_en and ex_rd = x -> alu_out (bypass).
  - else -> rf[x].
- Issue, on an accepting edge:
  - alu_op <= in_op.
  - alu_a <= read(in_rs1).
  - alu_b <= in_use_imm ? in_imm : read(in_rs2).
  - ex_rd <= in_rd.
  - ex_valid <= 1.
- Bubble: on a non-hold edge with no acceptance, ex_valid <= 0 and the other execute registers hold their values.
- Writeback:
  - wb_en = ex_valid & !hold; wb_addr = ex_rd; wb_data = alu_out.
  - On an edge with wb_en = 1 and ex_rd != 0: rf[ex_rd] <= alu_out.
  - Writes to r0 are dropped.
- Timing:
  - Accept at edge N; ALU inputs are stable during cycle N..N+1.
  - Result is written at edge N+1 and is visible on dbg_data after edge N+1.
  - Throughput is one instruction per cycle.
- hold = 1: no acceptance, no writeback; all execute registers, ex_valid and the register file are frozen. After hold deasserts, the frozen instruction writes back at the first following edge.
- Simultaneous writeback and issue reading the same register: the issuing instruction gets the new value via the bypass. Writeback to r0 plus a read of r0 yields 0.
- Arithmetic is entirely in the ALU; results wrap modulo 2^DW. This block performs no width extension.
- When ex_valid = 0, alu_out is ignored.

Test Plan:
- Immediate load then dependent add: ADD r1=r0+imm5 accepted at edge 1, then ADD r2=r1+imm7 at edge 2 (bypass) -> after edge 3, dbg r1=5, r2=12; in_ready stays 1 throughout.
- Register-register SUB: with r1=5 and r2=12, SUB r3=r2-r1 -> alu_a=12, alu_b=5 during execute; r3=7 one edge later.
- Wrap and r0: ADD r4=r0+imm200, ADD r4=r4+imm100 -> r4=44. Then ADD r0=r4+imm1 -> wb_en=1, wb_addr=0, r0 still reads 0.
- Hold: assert hold for 3 cycles while ex_valid=1 (ADD r5=r0+imm9) -> in_ready=0, wb_en=0, r5 unchanged. Deassert hold -> r5=9 on the next edge; an instruction held on in_valid is accepted on that same edge.
- Bubble: in_valid=0 for 2 cycles after one instruction -> ex_valid drops to 0 after the writeback edge, and no further register changes occur.
- Reset mid-operation: pulse rst_n low between accept and writeback of ADD r6=r0+imm3 -> ex_valid=0 immediately (asynchronous), all registers 0, and r6 is never written.
